// File: rtl/conv_window_controller.sv
// conv_window_controller
// Sequences the shift-register line buffer that feeds the convolver. It passes
// raster-order pixels into the buffer, tracks the row/column of each accepted
// pixel, raises window_valid once the buffer holds a complete KxK window,
// stalls the input while a window waits for the convolver, and pulses
// frame_done when the frame has been fully consumed.
//
// Optional feature: define CONV_STRIDE2_EN to emit only windows whose
// top-left row and column are both even (stride 2). Shifting is unchanged.
module conv_window_controller #(
    parameter int DATA_WIDTH   = 16,
    parameter int KERNEL_SIZE  = 3,
    parameter int IMAGE_WIDTH  = 5,
    parameter int IMAGE_HEIGHT = 5,
    parameter int COORD_WIDTH  = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [DATA_WIDTH-1:0]  pixel_in,
    input  logic                   pixel_valid,
    output logic                   pixel_ready,
    output logic [DATA_WIDTH-1:0]  shift_data,
    output logic                   shift_en,
    output logic                   sr_clear,
    output logic                   window_valid,
    input  logic                   window_ready,
    output logic [COORD_WIDTH-1:0] out_row,
    output logic [COORD_WIDTH-1:0] out_col,
    output logic                   busy,
    output logic                   frame_done
);

    localparam logic [COORD_WIDTH-1:0] LP_KM1 = COORD_WIDTH'(KERNEL_SIZE - 1);
    localparam logic [COORD_WIDTH-1:0] LP_WM1 = COORD_WIDTH'(IMAGE_WIDTH - 1);
    localparam logic [COORD_WIDTH-1:0] LP_HM1 = COORD_WIDTH'(IMAGE_HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic                   r_sr_clear;
    logic                   r_busy;
    logic                   r_frame_done;
    logic [COORD_WIDTH-1:0] r_row;
    logic [COORD_WIDTH-1:0] r_col;
    logic                   r_window_valid;
    logic [COORD_WIDTH-1:0] r_out_row;
    logic [COORD_WIDTH-1:0] r_out_col;

    logic                   w_pixel_ready;
    logic                   w_accept;
    logic                   w_last_col;
    logic                   w_last_pixel;
    logic                   w_qualify;
    logic [COORD_WIDTH-1:0] w_row_off;
    logic [COORD_WIDTH-1:0] w_col_off;

    // Input handshake, window qualification and end-of-row/frame detection
    always_comb begin
        w_pixel_ready = (r_state == S_STREAM) && (!r_window_valid || window_ready);
        w_accept      = pixel_valid && w_pixel_ready;
        w_last_col    = (r_col == LP_WM1);
        w_last_pixel  = w_last_col && (r_row == LP_HM1);
        w_row_off     = r_row - LP_KM1;
        w_col_off     = r_col - LP_KM1;
`ifdef CONV_STRIDE2_EN
        w_qualify     = (r_row >= LP_KM1) && (r_col >= LP_KM1) &&
                        !w_row_off[0] && !w_col_off[0];
`else
        w_qualify     = (r_row >= LP_KM1) && (r_col >= LP_KM1);
`endif
    end

    // Frame sequencing with registered control outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_sr_clear   <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_CLEAR;
                        r_sr_clear <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_state    <= S_STREAM;
                    r_sr_clear <= 1'b0;
                end
                S_STREAM: begin
                    if (w_accept && w_last_pixel) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Leave only after the final window has been consumed
                    if (!r_window_valid) begin
                        r_state      <= S_DONE;
                        r_frame_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state      <= S_IDLE;
                    r_frame_done <= 1'b0;
                    r_busy       <= 1'b0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_sr_clear   <= 1'b0;
                    r_busy       <= 1'b0;
                    r_frame_done <= 1'b0;
                end
            endcase
        end
    end

    // Raster position of the next pixel to be accepted
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (r_state == S_CLEAR) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_accept) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Window-valid flag and top-left coordinates, held until consumed
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_window_valid <= 1'b0;
            r_out_row      <= '0;
            r_out_col      <= '0;
        end else if (w_accept && w_qualify) begin
            r_window_valid <= 1'b1;
            r_out_row      <= w_row_off;
            r_out_col      <= w_col_off;
        end else if (r_window_valid && window_ready) begin
            r_window_valid <= 1'b0;
        end
    end

    assign pixel_ready  = w_pixel_ready;
    assign shift_en     = w_accept;
    assign shift_data   = w_accept ? pixel_in : '0;
    assign sr_clear     = r_sr_clear;
    assign window_valid = r_window_valid;
    assign out_row      = r_out_row;
    assign out_col      = r_out_col;
    assign busy         = r_busy;
    assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_conv_window_controller.sv
// Testbench for conv_window_controller (K=3, 5x5 frame).
// Expected windows are listed by hand; build with +define+CONV_STRIDE2_EN to
// select the stride-2 expectation table.
module tb_conv_window_controller;

    localparam int DW = 16;
    localparam int K  = 3;
    localparam int W  = 5;
    localparam int H  = 5;
    localparam int CW = 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] pixel_in = '0;
    logic          pixel_valid = 1'b0;
    logic          pixel_ready;
    logic [DW-1:0] shift_data;
    logic          shift_en;
    logic          sr_clear;
    logic          window_valid;
    logic          window_ready = 1'b0;
    logic [CW-1:0] out_row;
    logic [CW-1:0] out_col;
    logic          busy;
    logic          frame_done;

    conv_window_controller #(
        .DATA_WIDTH  (DW),
        .KERNEL_SIZE (K),
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .COORD_WIDTH (CW)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .pixel_in    (pixel_in),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .shift_data  (shift_data),
        .shift_en    (shift_en),
        .sr_clear    (sr_clear),
        .window_valid(window_valid),
        .window_ready(window_ready),
        .out_row     (out_row),
        .out_col     (out_col),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int row;
        int col;
    } win_t;

    typedef struct {
        int gap;        // 0: pixel_valid always 1, 1: pattern 1,0,0,1
        int stall;      // cycles of window_ready=0 on the second window
        bit hold_start; // keep start high throughout the frame
    } scen_t;

    win_t  exp_win[9];
    int    n_exp;
    scen_t scen[3];

    int checks   = 0;
    int failures = 0;

    int got_r[$];
    int got_c[$];
    int n_shift;
    int n_clear;
    int n_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pixel_ready"},  pixel_ready, 0);
        check({tag, "_shift_en"},     shift_en, 0);
        check({tag, "_shift_data"},   shift_data, 0);
        check({tag, "_sr_clear"},     sr_clear, 0);
        check({tag, "_window_valid"}, window_valid, 0);
        check({tag, "_out_row"},      out_row, 0);
        check({tag, "_out_col"},      out_col, 0);
        check({tag, "_busy"},         busy, 0);
        check({tag, "_frame_done"},   frame_done, 0);
    endtask

    // Drive one complete frame and verify it against exp_win
    task automatic run_frame(input int gap, input int stall, input bit hold_start);
        int  pix;
        int  stall_left;
        int  first_k;
        int  last_k;
        bit  prev_shift;
        bit  seen_first;
        bit  finished;
        got_r.delete();
        got_c.delete();
        n_shift = 0;
        n_clear = 0;
        n_done  = 0;
        pix = 1;
        stall_left = stall;
        first_k = -1;
        last_k = -1;
        prev_shift = 1'b0;
        seen_first = 1'b0;
        finished = 1'b0;

        @(negedge clock);
        start = 1'b1;
        pixel_valid = 1'b0;
        window_ready = 1'b1;
        @(negedge clock);
        if (!hold_start) start = 1'b0;

        for (int k = 0; k < 300 && !finished; k++) begin
            if (k > 0) @(negedge clock);
            pixel_valid  = (gap == 0) || (k % 4 == 0) || (k % 4 == 3);
            pixel_in     = DW'(pix);
            window_ready = 1'b1;
            if (window_valid && got_r.size() == 1 && stall_left > 0) begin
                window_ready = 1'b0;
                stall_left--;
            end
            #1;
            if (sr_clear) n_clear++;
            if (window_valid && !seen_first) begin
                seen_first = 1'b1;
                check("first_win_prev_cycle_accept", prev_shift, 1);
                check("first_win_after_pixel", pix - 1, 13);
            end
            if (!window_ready) begin
                check("stall_pixel_ready", pixel_ready, 0);
                check("stall_shift_en", shift_en, 0);
                check("stall_out_row", out_row, exp_win[1].row);
                check("stall_out_col", out_col, exp_win[1].col);
            end
            if (!pixel_valid) check("gap_shift_en", shift_en, 0);
            if (shift_en) begin
                check("shift_data", shift_data, pix);
                n_shift++;
                pix++;
                if (first_k < 0) first_k = k;
                last_k = k;
            end
            prev_shift = shift_en;
            if (window_valid && window_ready) begin
                got_r.push_back(int'(out_row));
                got_c.push_back(int'(out_col));
            end
            if (frame_done) begin
                n_done++;
                check("done_after_all_windows", got_r.size(), n_exp);
                check("done_window_valid", window_valid, 0);
                start = 1'b0;
                @(negedge clock);
                #1;
                check("idle_after_done_busy", busy, 0);
                check("frame_done_one_cycle", frame_done, 0);
                finished = 1'b1;
            end
        end

        if (!finished) check("frame_timeout", 1, 0);
        check("sr_clear_cycles", n_clear, 1);
        check("shift_count", n_shift, W * H);
        check("frame_done_count", n_done, 1);
        check("window_count", got_r.size(), n_exp);
        if (gap == 0 && stall == 0) check("shift_run_length", last_k - first_k + 1, W * H);
        for (int i = 0; i < n_exp; i++) begin
            if (i < got_r.size()) begin
                check($sformatf("win%0d_row", i), got_r[i], exp_win[i].row);
                check($sformatf("win%0d_col", i), got_c[i], exp_win[i].col);
            end
        end
        pixel_valid = 1'b0;
    endtask

    initial begin
        int cnt;

`ifdef CONV_STRIDE2_EN
        n_exp = 4;
        exp_win[0] = '{0, 0};
        exp_win[1] = '{0, 2};
        exp_win[2] = '{2, 0};
        exp_win[3] = '{2, 2};
        exp_win[4] = '{0, 0};
        exp_win[5] = '{0, 0};
        exp_win[6] = '{0, 0};
        exp_win[7] = '{0, 0};
        exp_win[8] = '{0, 0};
`else
        n_exp = 9;
        exp_win[0] = '{0, 0};
        exp_win[1] = '{0, 1};
        exp_win[2] = '{0, 2};
        exp_win[3] = '{1, 0};
        exp_win[4] = '{1, 1};
        exp_win[5] = '{1, 2};
        exp_win[6] = '{2, 0};
        exp_win[7] = '{2, 1};
        exp_win[8] = '{2, 2};
`endif
        scen[0] = '{0, 0, 1'b0};
        scen[1] = '{0, 4, 1'b0};
        scen[2] = '{1, 0, 1'b1};

        // Power-on reset with inputs active
        pixel_valid = 1'b1;
        window_ready = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check_all_zero("por");
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        #1;
        check("idle_pixel_ready", pixel_ready, 0);
        check("idle_shift_en", shift_en, 0);
        check("idle_busy", busy, 0);
        pixel_valid = 1'b0;

        for (int s = 0; s < 3; s++) begin
            run_frame(scen[s].gap, scen[s].stall, scen[s].hold_start);
        end

        // Mid-frame reset after 10 accepted pixels
        @(negedge clock);
        start = 1'b1;
        pixel_valid = 1'b0;
        window_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        pixel_valid = 1'b1;
        cnt = 0;
        for (int k = 0; k < 60 && cnt < 10; k++) begin
            #1;
            if (shift_en) cnt++;
            @(negedge clock);
        end
        check("midreset_pixels_before", cnt, 10);
        #1;
        check("midreset_busy_before", busy, 1);
        #1;
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            #1;
            check("midreset_no_frame_done", frame_done, 0);
        end
        pixel_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;

        run_frame(0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
